// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX holding logic (master) and the UART TX controller (slave).
// Carries the byte together with its per-frame configuration.
interface uart_tx_ctrl_if #(
    parameter int unsigned DIV_W = 16
) ();
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             parity_en;
    logic             parity_odd;
    logic [DIV_W-1:0] baud_div;

    modport master (
        output tx_valid,
        output tx_data,
        output parity_en,
        output parity_odd,
        output baud_div,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  parity_en,
        input  parity_odd,
        input  baud_div,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: latches one byte per handshake and paces the load/shift strobes
// of the external 11-bit TX shift register at the programmed bit period.
module uart_tx_ctrl #(
    parameter int unsigned DIV_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_ctrl_if.slave        bus,
    output logic [7:0]           tx_data_out,
    output logic                 tx_parity_add,
    output logic                 tx_parity_en,
    output logic                 tx_shift_reg_en,
    output logic                 tx_shift_en,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StWait} state_e;

    state_e           state_q;
    logic [3:0]       bit_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] per_cnt_q;
    logic [7:0]       data_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             load_q;
    logic             shift_q;
    logic             busy_q;
    logic             done_q;

    logic [DIV_W-1:0] div_eff;
    logic [3:0]       bits_total;
    logic [3:0]       bits_sent;
    logic             more_bits;
    logic             bit_end;
    logic             handshake;

    assign bus.tx_ready = (state_q == StIdle) && reset;
    assign handshake    = bus.tx_valid && bus.tx_ready;

    assign div_eff    = (bus.baud_div == '0) ? DIV_ONE : bus.baud_div;
    assign bits_total = par_en_q ? 4'd11 : 4'd10;
    // In SHIFT the counter has not yet absorbed the bit being shifted this cycle.
    assign bits_sent  = (state_q == StShift) ? bit_cnt_q + 4'd1 : bit_cnt_q;
    assign more_bits  = bits_sent < bits_total;
    assign bit_end    = ((state_q == StShift) && (div_q <= DIV_ONE)) ||
                        ((state_q == StWait) && (per_cnt_q == DIV_ONE));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            div_q     <= '0;
            per_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        data_q    <= bus.tx_data;
                        par_en_q  <= bus.parity_en;
                        par_odd_q <= bus.parity_odd;
                        div_q     <= div_eff;
                        state_q   <= StLoad;
                        load_q    <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StLoad: begin
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                    shift_q   <= 1'b1;
                end
                StShift: begin
                    bit_cnt_q <= bits_sent;
                    per_cnt_q <= div_q - DIV_ONE;
                    if (div_q > DIV_ONE) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    per_cnt_q <= per_cnt_q - DIV_ONE;
                end
            endcase

            // The stop bit is held a full period, so the frame ends at the last WAIT cycle.
            if (bit_end) begin
                if (more_bits) begin
                    state_q <= StShift;
                    shift_q <= 1'b1;
                end else begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign tx_data_out     = data_q;
    assign tx_parity_en    = par_en_q;
    assign tx_parity_add   = (^data_q) ^ par_odd_q;
    assign tx_shift_reg_en = load_q;
    assign tx_shift_en     = shift_q;
    assign tx_busy         = busy_q;
    assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a model of the external TX shift register.
module tb_uart_tx_ctrl;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned LogN  = 256;

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_tx_ctrl_if #(.DIV_W(DIV_W)) bus ();

    logic [7:0] tx_data_out;
    logic       tx_parity_add;
    logic       tx_parity_en;
    logic       tx_shift_reg_en;
    logic       tx_shift_en;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_ctrl #(.DIV_W(DIV_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .tx_data_out     (tx_data_out),
        .tx_parity_add   (tx_parity_add),
        .tx_parity_en    (tx_parity_en),
        .tx_shift_reg_en (tx_shift_reg_en),
        .tx_shift_en     (tx_shift_en),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Event logs, stamped with the edge count at the start of the cycle.
    int unsigned shift_cyc [LogN];
    int unsigned load_cyc  [LogN];
    int unsigned done_cyc  [LogN];
    logic        line_log  [LogN];
    int unsigned n_shift = 0, n_load = 0, n_done = 0, n_line = 0;
    logic [10:0] sr = '1;

    always @(negedge clock) begin
        if (!reset) begin
            sr = '1;
        end else if (tx_shift_reg_en) begin
            sr = tx_parity_en ? {1'b1, tx_parity_add, tx_data_out, 1'b0}
                              : {2'b11, tx_data_out, 1'b0};
        end else if (tx_shift_en) begin
            if (n_line < LogN) line_log[n_line] = sr[0];
            n_line++;
            sr = {1'b1, sr[10:1]};
        end
        if (tx_shift_en) begin
            if (n_shift < LogN) shift_cyc[n_shift] = cyc;
            n_shift++;
        end
        if (tx_shift_reg_en) begin
            if (n_load < LogN) load_cyc[n_load] = cyc;
            n_load++;
        end
        if (tx_done) begin
            if (n_done < LogN) done_cyc[n_done] = cyc;
            n_done++;
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned s_shift, s_load, s_done, s_line;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic snap();
        s_shift = n_shift;
        s_load  = n_load;
        s_done  = n_done;
        s_line  = n_line;
    endtask

    function automatic logic [10:0] line_vec(input int unsigned base, input int unsigned n);
        logic [10:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = line_log[base + i];
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic pe, input logic po,
                        input logic [15:0] div, output int unsigned t);
        bus.tx_data    = d;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.baud_div   = div;
        bus.tx_valid   = 1'b1;
        chk("ready_before_hs", {31'b0, bus.tx_ready}, 32'd1);
        @(posedge clock);
        #1;
        t = cyc;
        bus.tx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int unsigned t, input int unsigned div,
                               input int unsigned nbits, input int unsigned done_off,
                               input logic [10:0] exp_line);
        for (int i = 0; i < 200 && n_done <= s_done; i++) step(1);
        chk({tag, "_done_seen"}, n_done - s_done, 32'd1);
        chk({tag, "_done_cyc"}, done_cyc[s_done], t + done_off);
        chk({tag, "_done_lvl"}, {31'b0, tx_done}, 32'd1);
        chk({tag, "_ready_at_done"}, {31'b0, bus.tx_ready}, 32'd1);
        chk({tag, "_load_cyc"}, load_cyc[s_load], t);
        chk({tag, "_n_shift"}, n_shift - s_shift, nbits);
        for (int k = 0; k < nbits; k++)
            chk({tag, "_shift_cyc"}, shift_cyc[s_shift + k], t + 1 + k * div);
        chk({tag, "_line"}, {21'b0, line_vec(s_line, nbits)}, {21'b0, exp_line});
        step(1);
        chk({tag, "_done_drop"}, {31'b0, tx_done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'b0, tx_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned t1;

        bus.tx_valid   = 1'b1;
        bus.tx_data    = 8'hFF;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.baud_div   = 16'd4;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_ready", {31'b0, bus.tx_ready}, 32'd0);
            chk("rst_load", {31'b0, tx_shift_reg_en}, 32'd0);
            chk("rst_shift", {31'b0, tx_shift_en}, 32'd0);
            chk("rst_busy", {31'b0, tx_busy}, 32'd0);
            chk("rst_done", {31'b0, tx_done}, 32'd0);
        end
        bus.tx_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_release_ready", {31'b0, bus.tx_ready}, 32'd1);
        chk("rst_no_load", n_load, 32'd0);
        step(1);

        // 8N1, div 4, 0xA5
        snap();
        send(8'hA5, 1'b0, 1'b0, 16'd4, t);
        chk("8n1_busy", {31'b0, tx_busy}, 32'd1);
        check_frame("8n1", t, 4, 10, 41, 11'h34A);
        step(2);
        chk("8n1_hold_data", {24'b0, tx_data_out}, 32'h0000_00A5);
        chk("8n1_par_en", {31'b0, tx_parity_en}, 32'd0);

        // Even parity, div 3, 0x07; inputs change mid-frame
        snap();
        send(8'h07, 1'b1, 1'b0, 16'd3, t);
        chk("even_par_add", {31'b0, tx_parity_add}, 32'd1);
        chk("even_par_en", {31'b0, tx_parity_en}, 32'd1);
        bus.tx_data    = 8'hFF;
        bus.parity_odd = 1'b1;
        bus.baud_div   = 16'd9;
        step(5);
        chk("even_par_stable", {31'b0, tx_parity_add}, 32'd1);
        check_frame("even", t, 3, 11, 34, 11'h60E);

        // Odd parity, same byte
        snap();
        send(8'h07, 1'b1, 1'b1, 16'd3, t);
        chk("odd_par_add", {31'b0, tx_parity_add}, 32'd0);
        check_frame("odd", t, 3, 11, 34, 11'h40E);

        // Divisor 0 behaves as 1
        snap();
        send(8'h81, 1'b0, 1'b0, 16'd0, t);
        check_frame("div0", t, 1, 10, 11, 11'h302);

        snap();
        send(8'h00, 1'b0, 1'b0, 16'd1, t);
        check_frame("div1", t, 1, 10, 11, 11'h200);

        // Back-to-back with tx_valid held high
        snap();
        bus.tx_data    = 8'h3C;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.baud_div   = 16'd2;
        bus.tx_valid   = 1'b1;
        @(posedge clock);
        #1;
        t1 = cyc;
        bus.tx_data = 8'hC3;
        step(4);
        chk("b2b_data1", {24'b0, tx_data_out}, 32'h0000_003C);
        chk("b2b_busy1", {31'b0, tx_busy}, 32'd1);
        for (int i = 0; i < 100 && n_load < s_load + 2; i++) step(1);
        bus.tx_valid = 1'b0;
        chk("b2b_n_load", n_load - s_load, 32'd2);
        chk("b2b_load1", load_cyc[s_load], t1);
        chk("b2b_done1", done_cyc[s_done], t1 + 21);
        chk("b2b_load2", load_cyc[s_load + 1], t1 + 22);
        chk("b2b_data2", {24'b0, tx_data_out}, 32'h0000_00C3);
        chk("b2b_line1", {21'b0, line_vec(s_line, 10)}, 32'h0000_0278);
        bus.parity_en = 1'b1;
        bus.baud_div  = 16'd1;
        step(5);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 100 && n_done < s_done + 2; i++) step(1);
        chk("b2b_n_done", n_done - s_done, 32'd2);
        chk("b2b_no_extra_load", n_load - s_load, 32'd2);
        chk("b2b_done2", done_cyc[s_done + 1], t1 + 43);
        chk("b2b_n_shift", n_shift - s_shift, 32'd20);
        chk("b2b_data_kept", {24'b0, tx_data_out}, 32'h0000_00C3);
        chk("b2b_line2", {21'b0, line_vec(s_line + 10, 10)}, 32'h0000_0386);
        step(1);

        // Reset during the 5th bit aborts the frame
        snap();
        send(8'h96, 1'b0, 1'b0, 16'd4, t);
        for (int i = 0; i < 100 && n_shift < s_shift + 5; i++) step(1);
        chk("abort_n_shift", n_shift - s_shift, 32'd5);
        reset = 1'b0;
        step(1);
        chk("abort_busy", {31'b0, tx_busy}, 32'd0);
        chk("abort_shift", {31'b0, tx_shift_en}, 32'd0);
        chk("abort_load", {31'b0, tx_shift_reg_en}, 32'd0);
        chk("abort_done", {31'b0, tx_done}, 32'd0);
        chk("abort_ready", {31'b0, bus.tx_ready}, 32'd0);
        step(1);
        reset = 1'b1;
        #1;
        chk("abort_ready_rel", {31'b0, bus.tx_ready}, 32'd1);
        step(6);
        chk("abort_no_done", n_done - s_done, 32'd0);
        chk("abort_no_more_shift", n_shift - s_shift, 32'd5);

        snap();
        send(8'h5A, 1'b0, 1'b0, 16'd1, t);
        check_frame("post_rst", t, 1, 10, 11, 11'h2B4);
        chk("post_rst_data", {24'b0, tx_data_out}, 32'h0000_005A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
